tt_sweep_ctrl: RTL and testbench
================================

Name: tt_sweep_ctrl

Overview:
Sequencer that exhaustively exercises a 5-input combinational function block (inputs a..e, output f). It drives every input combination in binary order, holds each for a programmable settle time, samples f, and builds the captured truth table. It compares the captured table against a supplied expected table and reports the result through a start/done handshake. It sits between a lab control/status path and any single-output combinational lab datapath, replacing hand-written vector sweeps.

Parameters:
N_IN, 5, number of function inputs; vec_out[N_IN-1] drives a (MSB), vec_out[0] drives e (LSB)
SETTLE, 2, cycles each vector is held before sampling; legal range 1..15
N_VEC, 2**N_IN (derived, localparam), number of vectors in one sweep

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request a sweep; sampled only in IDLE
abort  in  1  cancel a sweep in progress
exp_tt  in  N_VEC  expected truth table; bit i = expected f for vector i
f_in  in  1  output f of the function block under control (combinational)
vec_out  out  N_IN  current input vector to the function block
busy  out  1  high while a sweep is in progress (WAIT or SAMPLE)
done  out  1  one-cycle pulse when a sweep completes
pass  out  1  1 when the last completed sweep had zero mismatches
tt_out  out  N_VEC  captured truth table; bit i = sampled f for vector i
err_count  out  N_IN+1  number of mismatching vectors in the current/last sweep
first_err  out  N_IN  index of the lowest mismatching vector
first_err_vld  out  1  first_err holds a valid index

Behaviour:
- Reset (async, immediate): state=IDLE; vec_out=0, busy=0, done=0, pass=0, tt_out=0, err_count=0, first_err=0, first_err_vld=0, internal exp latch=0, wait counter=0.
- States: IDLE, WAIT, SAMPLE, FIN.
- IDLE -> WAIT on start=1. Same edge: latch exp_tt; clear vec_out, tt_out, err_count, first_err, first_err_vld, pass; wait_cnt=0.
- WAIT: hold vec_out; wait_cnt++ each cycle. When wait_cnt==SETTLE-1, go to SAMPLE. Total time in WAIT per vector is SETTLE cycles.
- SAMPLE (1 cycle), on its edge:
  - tt_out[vec_out] <= f_in.
  - If f_in != exp_latch[vec_out]: err_count++. If first_err_vld=0, also set first_err=vec_out and first_err_vld=1.
  - If vec_out==N_VEC-1, go to FIN (no wrap, vec_out held). Otherwise vec_out++, wait_cnt=0, go to WAIT.
- FIN (1 cycle): done=1 and pass=(err_count==0), then go to IDLE. pass, tt_out, err_count and first_err* hold until the next accepted start or reset.
- Timing: with start sampled at edge k, done is high during the cycle following edge k+N_VEC*(SETTLE+1). With defaults, that is k+96.
- busy=1 exactly in WAIT and SAMPLE.
- start while busy or in FIN is ignored (no restart, no timing change).
- abort=1 in WAIT or SAMPLE (priority over SAMPLE update): next state IDLE, vec_out=0, no done pulse, pass=0. tt_out, err_count and first_err* keep their partial values. abort in IDLE or FIN has no effect.
- start and abort both high in IDLE: start wins (abort only acts when busy).
- exp_tt changes during a sweep have no effect; the latched copy is used.
- err_count is N_IN+1 bits so that all N_VEC mismatches (32) are representable without wrap.

Test Plan:
1. Function block = golden function, exp_tt = its table, SETTLE=2, start pulse at edge k -> vec_out steps 0..31, each held 3 cycles; done pulse at k+96 only; pass=1, err_count=0, first_err_vld=0, tt_out==exp_tt.
2. Same block, exp_tt with bits 5 and 20 inverted -> err_count=2, first_err=5, first_err_vld=1, pass=0, tt_out equals the true table.
3. f_in tied 0, exp_tt=32'hFFFFFFFF -> err_count=32 (6'b100000), first_err=0, pass=0, tt_out=0.
4. start re-pulsed at vector 12 during a sweep -> ignored; done still at k+96; vec_out sequence is unbroken.
5. abort at vector 10 (WAIT) -> IDLE next edge, busy=0, vec_out=0, no done, pass=0; a following start runs a full, correct 96-cycle sweep.
6. rst pulsed asynchronously mid-SETTLE at vector 17 -> all outputs go to reset values before the next clk edge; state=IDLE; start after release sweeps normally.

Source files
------------

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: walks a 5-input combinational block through every vector,
// samples its output after a settle time, and grades the captured table against an expected one.
module tt_sweep_ctrl #(
    parameter  int N_IN   = 5,
    parameter  int SETTLE = 2,
    localparam int N_VEC  = 2 ** N_IN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_VEC-1:0] exp_tt,
    input  logic             f_in,
    output logic [N_IN-1:0]  vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_VEC-1:0] tt_out,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_err,
    output logic             first_err_vld
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        FIN
    } state_t;

    state_t             state_q;
    logic [N_IN-1:0]    vec_q;
    logic [3:0]         waitCnt_q;
    logic [N_VEC-1:0]   expTt_q;
    logic [N_VEC-1:0]   tt_q;
    logic [N_IN:0]      errCnt_q;
    logic [N_IN-1:0]    firstErr_q;
    logic               firstErrVld_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;

    logic               mismatch;
    logic               lastVec;
    logic               settled;
    logic [N_IN:0]      errCnt_d;

    // The pass verdict must include the mismatch being recorded on the final sample edge.
    always_comb begin
        mismatch = f_in ^ expTt_q[vec_q];
        lastVec  = (vec_q == N_IN'(N_VEC - 1));
        settled  = (waitCnt_q == 4'(SETTLE - 1));
        errCnt_d = errCnt_q;
        if (mismatch) begin
            errCnt_d = errCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            vec_q         <= '0;
            waitCnt_q     <= '0;
            expTt_q       <= '0;
            tt_q          <= '0;
            errCnt_q      <= '0;
            firstErr_q    <= '0;
            firstErrVld_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= WAIT;
                        expTt_q       <= exp_tt;
                        vec_q         <= '0;
                        waitCnt_q     <= '0;
                        tt_q          <= '0;
                        errCnt_q      <= '0;
                        firstErr_q    <= '0;
                        firstErrVld_q <= 1'b0;
                        pass_q        <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        vec_q     <= '0;
                        waitCnt_q <= '0;
                        busy_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end else begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                        if (settled) begin
                            state_q <= SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    // Abort wins over the sample so a cancelled vector never lands in the table.
                    if (abort) begin
                        state_q   <= IDLE;
                        vec_q     <= '0;
                        waitCnt_q <= '0;
                        busy_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end else begin
                        tt_q[vec_q] <= f_in;
                        errCnt_q    <= errCnt_d;
                        if (mismatch && !firstErrVld_q) begin
                            firstErr_q    <= vec_q;
                            firstErrVld_q <= 1'b1;
                        end
                        if (lastVec) begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (errCnt_d == '0);
                        end else begin
                            state_q   <= WAIT;
                            vec_q     <= vec_q + 1'b1;
                            waitCnt_q <= '0;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_out       = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign tt_out        = tt_q;
    assign err_count     = errCnt_q;
    assign first_err     = firstErr_q;
    assign first_err_vld = firstErrVld_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Randomized self-checking bench for tt_sweep_ctrl; a random golden table stands in for the
// function block and expectations come from popcount / lowest-set-bit arithmetic on tables.
module tb_tt_sweep_ctrl;

    localparam int N_IN   = 5;
    localparam int SETTLE = 2;
    localparam int N_VEC  = 2 ** N_IN;
    localparam int PERIOD = SETTLE + 1;
    localparam int TOTAL  = N_VEC * PERIOD;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [N_VEC-1:0] exp_tt;
    logic             fIn;
    logic [N_IN-1:0]  vecOut;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_VEC-1:0] ttOut;
    logic [N_IN:0]    errCount;
    logic [N_IN-1:0]  firstErr;
    logic             firstErrVld;

    logic [N_VEC-1:0] goldTt;
    logic             fTieLow;

    int compared;
    int mismatched;

    int               badCycle;
    logic [N_IN-1:0]  snapVec;
    logic [N_VEC-1:0] snapTt;
    logic [N_IN:0]    snapErr;
    logic [N_IN-1:0]  snapFe;
    logic [3:0]       snapFlags;

    tt_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .exp_tt       (exp_tt),
        .f_in         (fIn),
        .vec_out      (vecOut),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .tt_out       (ttOut),
        .err_count    (errCount),
        .first_err    (firstErr),
        .first_err_vld(firstErrVld)
    );

    // The function block under control is a lookup into a random golden table.
    assign fIn = fTieLow ? 1'b0 : goldTt[vecOut];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int popCount(input logic [N_VEC-1:0] v);
        int n = 0;
        for (int i = 0; i < N_VEC; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int lowestSet(input logic [N_VEC-1:0] v);
        for (int i = 0; i < N_VEC; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Starts a sweep and follows it cycle by cycle against the ideal timeline:
    // vector j/PERIOD while busy, a single done at cycle TOTAL, idle after an abort.
    task automatic sweepDrive(input logic [N_VEC-1:0] expTt, input int restartVec,
                              input int abortVec, input int rstCycle, input bit withAbort);
        logic [N_IN-1:0] eVec;
        logic            eBusy;
        logic            eDone;
        bit              aborted = 0;
        int              abortCycle = -10;
        @(negedge clk);
        exp_tt = expTt;
        start  = 1'b1;
        abort  = withAbort;
        @(posedge clk);
        badCycle = -1;
        for (int j = 0; j <= TOTAL + 2; j++) begin
            @(negedge clk);
            start  = 1'b0;
            abort  = 1'b0;
            exp_tt = N_VEC'($urandom);
            if (aborted) begin
                eBusy = 1'b0; eVec = '0; eDone = 1'b0;
            end else if (j < TOTAL) begin
                eBusy = 1'b1; eVec = N_IN'(j / PERIOD); eDone = 1'b0;
            end else begin
                eBusy = 1'b0; eVec = N_IN'(N_VEC - 1); eDone = (j == TOTAL);
            end
            if (badCycle < 0 && (busy !== eBusy || vecOut !== eVec || done !== eDone ||
                                 (aborted && pass !== 1'b0)))
                badCycle = j;
            if (aborted && j >= abortCycle + 4) break;
            if (restartVec >= 0 && j == restartVec * PERIOD) start = 1'b1;
            if (abortVec >= 0 && j == abortVec * PERIOD) begin
                abort = 1'b1; aborted = 1; abortCycle = j;
            end
            if (rstCycle >= 0 && j == rstCycle) begin
                #2 rst = 1'b1;
                #1;
                snapVec   = vecOut;
                snapTt    = ttOut;
                snapErr   = errCount;
                snapFe    = firstErr;
                snapFlags = {busy, done, pass, firstErrVld};
                #1 rst = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; exp_tt = '0; fTieLow = 1'b0;
        goldTt = N_VEC'($urandom);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({busy, done, pass, firstErrVld} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags got=%b want=0000", {busy, done, pass, firstErrVld});
        end
        compared++;
        if (vecOut !== '0 || ttOut !== '0 || errCount !== '0 || firstErr !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_values got vec=%0d tt=%h err=%0d fe=%0d want all 0",
                     vecOut, ttOut, errCount, firstErr);
        end
    endtask

    // One complete sweep, graded against table arithmetic on the true and expected tables.
    task automatic test_full_sweep(input string name, input logic [N_VEC-1:0] expTt,
                                   input bit tieLow, input int restartVec, input bit withAbort);
        logic [N_VEC-1:0] trueTt;
        logic [N_VEC-1:0] diff;
        int               eErr;
        fTieLow = tieLow;
        trueTt  = tieLow ? '0 : goldTt;
        diff    = trueTt ^ expTt;
        eErr    = popCount(diff);
        sweepDrive(expTt, restartVec, -1, -1, withAbort);
        compared++;
        if (badCycle != -1) begin
            mismatched++;
            $display("[TB] FAIL %s_timeline first bad cycle=%0d want none", name, badCycle);
        end
        compared++;
        if (ttOut !== trueTt) begin
            mismatched++;
            $display("[TB] FAIL %s_tt got=%h want=%h", name, ttOut, trueTt);
        end
        compared++;
        if (errCount !== (N_IN + 1)'(eErr)) begin
            mismatched++;
            $display("[TB] FAIL %s_err_count got=%0d want=%0d", name, errCount, eErr);
        end
        compared++;
        if (firstErrVld !== (eErr != 0) || firstErr !== N_IN'(lowestSet(diff))) begin
            mismatched++;
            $display("[TB] FAIL %s_first_err got=%0d/%b want=%0d/%b", name, firstErr,
                     firstErrVld, lowestSet(diff), eErr != 0);
        end
        compared++;
        if (pass !== (eErr == 0)) begin
            mismatched++;
            $display("[TB] FAIL %s_pass got=%b want=%b", name, pass, eErr == 0);
        end
    endtask

    task automatic test_golden();
        test_full_sweep("golden", goldTt, 1'b0, -1, 1'b0);
    endtask

    task automatic test_mismatch();
        logic [N_VEC-1:0] flips = (N_VEC'(1) << 5) | (N_VEC'(1) << 20);
        test_full_sweep("two_errors", goldTt ^ flips, 1'b0, -1, 1'b0);
        test_full_sweep("random_exp", N_VEC'($urandom), 1'b0, -1, 1'b0);
    endtask

    task automatic test_all_fail();
        test_full_sweep("all_fail", '1, 1'b1, -1, 1'b0);
        fTieLow = 1'b0;
    endtask

    task automatic test_idle_abort();
        logic [N_VEC-1:0] heldTt = ttOut;
        logic             heldPass = pass;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (pass !== heldPass || ttOut !== heldTt || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_abort got pass=%b tt=%h busy=%b want pass=%b tt=%h busy=0",
                     pass, ttOut, busy, heldPass, heldTt);
        end
    endtask

    task automatic test_restart_ignored();
        test_full_sweep("restart_ignored", goldTt ^ N_VEC'($urandom), 1'b0, 12, 1'b0);
    endtask

    task automatic test_start_with_abort();
        test_full_sweep("start_abort_idle", goldTt, 1'b0, -1, 1'b1);
    endtask

    task automatic test_abort();
        logic [N_VEC-1:0] expTt = goldTt ^ N_VEC'($urandom);
        logic [N_VEC-1:0] mask = (N_VEC'(1) << 10) - 1'b1;
        logic [N_VEC-1:0] diff = (goldTt ^ expTt) & mask;
        sweepDrive(expTt, -1, 10, -1, 1'b0);
        compared++;
        if (badCycle != -1) begin
            mismatched++;
            $display("[TB] FAIL abort_timeline first bad cycle=%0d want none", badCycle);
        end
        compared++;
        if (ttOut !== (goldTt & mask) || errCount !== (N_IN + 1)'(popCount(diff))) begin
            mismatched++;
            $display("[TB] FAIL abort_partial got tt=%h err=%0d want tt=%h err=%0d",
                     ttOut, errCount, goldTt & mask, popCount(diff));
        end
        compared++;
        if (firstErrVld !== (diff != '0) || firstErr !== N_IN'(lowestSet(diff))) begin
            mismatched++;
            $display("[TB] FAIL abort_first_err got=%0d/%b want=%0d/%b", firstErr,
                     firstErrVld, lowestSet(diff), diff != '0);
        end
        test_full_sweep("after_abort", goldTt ^ N_VEC'($urandom), 1'b0, -1, 1'b0);
    endtask

    task automatic test_async_reset();
        goldTt = N_VEC'($urandom);
        sweepDrive(~goldTt, -1, -1, 17 * PERIOD + 1, 1'b0);
        compared++;
        if (badCycle != -1) begin
            mismatched++;
            $display("[TB] FAIL pre_reset_timeline first bad cycle=%0d want none", badCycle);
        end
        compared++;
        if (snapVec !== '0 || snapTt !== '0 || snapErr !== '0 || snapFe !== '0 ||
            snapFlags !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL async_reset got vec=%0d tt=%h err=%0d fe=%0d flags=%b want all 0",
                     snapVec, snapTt, snapErr, snapFe, snapFlags);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || vecOut !== '0) begin
            mismatched++;
            $display("[TB] FAIL post_reset_idle got busy=%b vec=%0d want 0/0", busy, vecOut);
        end
        test_full_sweep("after_reset", goldTt, 1'b0, -1, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_golden();
        test_idle_abort();
        test_mismatch();
        test_all_fail();
        test_restart_ignored();
        test_start_with_abort();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
